// File: rtl/desc_pkg.sv
// Shared widths and state encoding for the descriptor packer and the NCC matcher.
package desc_pkg;

  localparam int PIX_W          = 8;
  localparam int PIX_PER_WORD   = 4;
  localparam int WORDS_PER_DESC = 16;
  localparam int DESC_WORD_W    = 32;
  localparam int SUM_W          = 14;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2
  } desc_state_e;

endpackage

// File: rtl/desc_packer.sv
// Packs serial 8-bit descriptor pixels four per 32-bit word for the NCC matcher.
// Optional per-descriptor pixel sum on desc_sum when DESC_SUM_EN is defined.
module desc_packer
  import desc_pkg::*;
#(
  parameter int WORD_GAP = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PIX_W-1:0]       pix_in,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  output logic                   desc_data_ready,
  output logic [DESC_WORD_W-1:0] desc_data_out,
  output logic                   desc_done
`ifdef DESC_SUM_EN
  ,
  output logic [SUM_W-1:0]       desc_sum
`endif
);

  localparam int PIX_CNT_W  = $clog2(PIX_PER_WORD);
  localparam int WORD_CNT_W = $clog2(WORDS_PER_DESC);
  localparam int GAP_CNT_W  = (WORD_GAP > 1) ? $clog2(WORD_GAP) : 1;
  localparam int PACK_W     = PIX_W * (PIX_PER_WORD - 1);

  desc_state_e             state_q, state_d;
  logic [PIX_CNT_W-1:0]    pix_cnt_q, pix_cnt_d;
  logic [WORD_CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [GAP_CNT_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [PACK_W-1:0]       pack_q, pack_d;
  logic [DESC_WORD_W-1:0]  data_q, data_d;

  logic xfer;
  logic last_pix;
  logic last_word;

  // Outputs are gated by rst so nothing is offered or strobed while reset is held.
  assign pix_ready       = (state_q == FILL) && !rst;
  assign desc_data_ready = (state_q == EMIT) && !rst;
  assign desc_done       = desc_data_ready && last_word;
  assign desc_data_out   = data_q;

  assign xfer      = pix_valid && pix_ready;
  assign last_pix  = (pix_cnt_q == PIX_CNT_W'(PIX_PER_WORD - 1));
  assign last_word = (word_cnt_q == WORD_CNT_W'(WORDS_PER_DESC - 1));

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    word_cnt_d = word_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    pack_d     = pack_q;
    data_d     = data_q;
    case (state_q)
      FILL: begin
        if (xfer) begin
          pack_d    = {pack_q[PACK_W-PIX_W-1:0], pix_in};
          pix_cnt_d = pix_cnt_q + 1'b1;
          if (last_pix) begin
            data_d  = {pack_q, pix_in};
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        word_cnt_d = word_cnt_q + 1'b1;
        state_d    = (WORD_GAP > 0) ? GAP : FILL;
      end
      GAP: begin
        if (gap_cnt_q == GAP_CNT_W'(WORD_GAP - 1)) begin
          gap_cnt_d = '0;
          state_d   = FILL;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q    <= FILL;
      pix_cnt_q  <= '0;
      word_cnt_q <= '0;
      gap_cnt_q  <= '0;
      pack_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      pix_cnt_q  <= pix_cnt_d;
      word_cnt_q <= word_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      pack_q     <= pack_d;
      data_q     <= data_d;
    end
  end

`ifdef DESC_SUM_EN
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             desc_start;

  // First pixel of a descriptor restarts the running total instead of adding to it.
  assign desc_start = (word_cnt_q == '0) && (pix_cnt_q == '0);
  assign desc_sum   = sum_q;

  always_comb begin
    acc_d = acc_q;
    sum_d = sum_q;
    if (xfer) begin
      acc_d = (desc_start ? '0 : acc_q) + SUM_W'(pix_in);
      if (last_pix && last_word) begin
        sum_d = acc_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      sum_q <= '0;
    end else begin
      acc_q <= acc_d;
      sum_q <= sum_d;
    end
  end
`endif

endmodule
